// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- execute stage of a simple in-order pipeline.
//
// Holds the ID/EX pipeline register, resolves operand forwarding from the
// EX/MEM register and the writeback port, stalls on load-use hazards, drives
// operands to an external combinational ALU, resolves taken branches into a
// fetch redirect, and holds the EX/MEM register towards the memory stage.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   id_valid / id_ready        decode -> execute handshake
//   id_pc, id_imm              instruction address and immediate
//   id_rs1_data, id_rs2_data   register-file read data captured at decode
//   id_rs1, id_rs2, id_rd      register indices
//   id_alu_op                  requested ALU operation
//   id_use_imm, id_is_branch,
//   id_is_load, id_reg_write   control flags
//   alu_op1, alu_op2,
//   alu_operation              operands / operation driven to the ALU
//   alu_result                 combinational ALU result for those operands
//   wb_valid, wb_rd, wb_data   writeback forwarding source
//   mem_valid / mem_ready      execute -> memory handshake
//   mem_result, mem_rs2_data,
//   mem_rd, mem_is_load,
//   mem_reg_write              EX/MEM register contents
//   redirect_valid,
//   redirect_pc                taken-branch redirect to fetch
// ---------------------------------------------------------------------------

package core_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9,
      ALU_BEQ  = 4'd10,
      ALU_BNE  = 4'd11,
      ALU_BLT  = 4'd12,
      ALU_BGE  = 4'd13,
      ALU_BGEU = 4'd14,
      ALU_BLTU = 4'd15
   } alu_op_t;

   // Branch compares occupy the top of the encoding, BEQ upwards.
   function automatic logic is_branch_op(input alu_op_t op);
      return (op >= ALU_BEQ);
   endfunction

endpackage

module ex_stage
   import core_pkg::*;
#(
   parameter int Data_Width = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,

   input  logic                  id_valid,
   output logic                  id_ready,
   input  logic [Data_Width-1:0] id_pc,
   input  logic [Data_Width-1:0] id_imm,
   input  logic [Data_Width-1:0] id_rs1_data,
   input  logic [Data_Width-1:0] id_rs2_data,
   input  logic [4:0]            id_rs1,
   input  logic [4:0]            id_rs2,
   input  logic [4:0]            id_rd,
   input  alu_op_t               id_alu_op,
   input  logic                  id_use_imm,
   input  logic                  id_is_branch,
   input  logic                  id_is_load,
   input  logic                  id_reg_write,

   output logic [Data_Width-1:0] alu_op1,
   output logic [Data_Width-1:0] alu_op2,
   output alu_op_t               alu_operation,
   input  logic [Data_Width-1:0] alu_result,

   input  logic                  wb_valid,
   input  logic [4:0]            wb_rd,
   input  logic [Data_Width-1:0] wb_data,

   output logic                  mem_valid,
   input  logic                  mem_ready,
   output logic [Data_Width-1:0] mem_result,
   output logic [Data_Width-1:0] mem_rs2_data,
   output logic [4:0]            mem_rd,
   output logic                  mem_is_load,
   output logic                  mem_reg_write,

   output logic                  redirect_valid,
   output logic [Data_Width-1:0] redirect_pc
);

   // ------------------------------------------------------------------
   // ID/EX register
   // ------------------------------------------------------------------
   logic                  ex_valid_q,     ex_valid_d;
   logic [Data_Width-1:0] pc_q,           pc_d;
   logic [Data_Width-1:0] imm_q,          imm_d;
   logic [Data_Width-1:0] rs1_data_q,     rs1_data_d;
   logic [Data_Width-1:0] rs2_data_q,     rs2_data_d;
   logic [4:0]            rs1_q,          rs1_d;
   logic [4:0]            rs2_q,          rs2_d;
   logic [4:0]            rd_q,           rd_d;
   alu_op_t               alu_op_q,       alu_op_d;
   logic                  use_imm_q,      use_imm_d;
   logic                  is_branch_q,    is_branch_d;
   logic                  is_load_q,      is_load_d;
   logic                  reg_write_q,    reg_write_d;

   // ------------------------------------------------------------------
   // EX/MEM register
   // ------------------------------------------------------------------
   logic                  mem_valid_q,     mem_valid_d;
   logic [Data_Width-1:0] mem_result_q,    mem_result_d;
   logic [Data_Width-1:0] mem_rs2_data_q,  mem_rs2_data_d;
   logic [4:0]            mem_rd_q,        mem_rd_d;
   logic                  mem_is_load_q,   mem_is_load_d;
   logic                  mem_reg_write_q, mem_reg_write_d;

   // ------------------------------------------------------------------
   // Execute-cycle combinational signals
   // ------------------------------------------------------------------
   logic [Data_Width-1:0] fwd_rs1;
   logic [Data_Width-1:0] fwd_rs2;
   logic                  mem_fwd_ok;
   logic                  mem_load_pending;
   logic                  hold;
   logic                  ex_fire;
   logic                  ex_branch;
   logic                  take_branch;
   logic [Data_Width-1:0] branch_target;

   // A branch is recognised either by its decode flag or by its opcode, so
   // operand mapping, redirect and write suppression always agree.
   assign ex_branch = is_branch_q | is_branch_op(alu_op_q);

   // A load result is not available until it reaches writeback, so an
   // EX/MEM load is never a forwarding source; it stalls instead.
   assign mem_fwd_ok       = mem_valid_q & mem_reg_write_q & ~mem_is_load_q;
   assign mem_load_pending = mem_valid_q & mem_is_load_q & (mem_rd_q != 5'd0);

   assign hold = ex_valid_q & mem_load_pending &
                 ((mem_rd_q == rs1_q) | (mem_rd_q == rs2_q));

   assign ex_fire  = ex_valid_q & ~hold & (~mem_valid_q | mem_ready);
   assign id_ready = ~ex_valid_q | ex_fire;

   // Forwarding priority: EX/MEM, then WB, then the captured value.
   // x0 is hard-wired and always uses the captured value.
   always_comb begin
      // NOTE: every combinationally assigned variable gets a default first,
      // so no path leaves it unassigned and no latch is inferred.
      fwd_rs1 = rs1_data_q;
      fwd_rs2 = rs2_data_q;
      if (rs1_q != 5'd0) begin
         if (mem_fwd_ok && (mem_rd_q == rs1_q)) begin
            fwd_rs1 = mem_result_q;
         end else if (wb_valid && (wb_rd == rs1_q)) begin
            fwd_rs1 = wb_data;
         end
      end
      if (rs2_q != 5'd0) begin
         if (mem_fwd_ok && (mem_rd_q == rs2_q)) begin
            fwd_rs2 = mem_result_q;
         end else if (wb_valid && (wb_rd == rs2_q)) begin
            fwd_rs2 = wb_data;
         end
      end
   end

   // Operand mapping. The ALU computes SUB as op2 - op1, hence the swap.
   // Shifts follow the regular mapping; the ALU takes op2[4:0] as amount.
   always_comb begin
      alu_operation = ALU_ADD;
      alu_op1       = '0;
      alu_op2       = '0;
      if (ex_valid_q) begin
         alu_operation = alu_op_q;
         if (ex_branch) begin
            alu_op1 = fwd_rs1;
            alu_op2 = fwd_rs2;
         end else if (alu_op_q == ALU_SUB) begin
            alu_op1 = fwd_rs2;
            alu_op2 = fwd_rs1;
         end else begin
            alu_op1 = fwd_rs1;
            alu_op2 = use_imm_q ? imm_q : fwd_rs2;
         end
      end
   end

   // Target adder is local so the ALU is free for the compare; it wraps.
   assign branch_target  = pc_q + imm_q;
   assign take_branch    = ex_fire & ex_branch & alu_result[0];
   assign redirect_valid = take_branch;
   assign redirect_pc    = take_branch ? branch_target : '0;

   // ------------------------------------------------------------------
   // ID/EX next state
   // ------------------------------------------------------------------
   always_comb begin
      ex_valid_d  = ex_valid_q;
      pc_d        = pc_q;
      imm_d       = imm_q;
      rs1_data_d  = rs1_data_q;
      rs2_data_d  = rs2_data_q;
      rs1_d       = rs1_q;
      rs2_d       = rs2_q;
      rd_d        = rd_q;
      alu_op_d    = alu_op_q;
      use_imm_d   = use_imm_q;
      is_branch_d = is_branch_q;
      is_load_d   = is_load_q;
      reg_write_d = reg_write_q;

      if (take_branch) begin
         // The instruction being offered is on the wrong path: the
         // handshake completes (id_ready is high) but it is squashed.
         ex_valid_d = 1'b0;
      end else if (id_valid && id_ready) begin
         ex_valid_d  = 1'b1;
         pc_d        = id_pc;
         imm_d       = id_imm;
         rs1_data_d  = id_rs1_data;
         rs2_data_d  = id_rs2_data;
         rs1_d       = id_rs1;
         rs2_d       = id_rs2;
         rd_d        = id_rd;
         alu_op_d    = id_alu_op;
         use_imm_d   = id_use_imm;
         is_branch_d = id_is_branch;
         is_load_d   = id_is_load;
         reg_write_d = id_reg_write;
      end else if (ex_fire) begin
         ex_valid_d = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // EX/MEM next state. Payload only changes on ex_fire, and ex_fire
   // requires the slot to be empty or draining, so a stalled entry is
   // never disturbed.
   // ------------------------------------------------------------------
   always_comb begin
      mem_valid_d     = mem_valid_q;
      mem_result_d    = mem_result_q;
      mem_rs2_data_d  = mem_rs2_data_q;
      mem_rd_d        = mem_rd_q;
      mem_is_load_d   = mem_is_load_q;
      mem_reg_write_d = mem_reg_write_q;

      if (ex_fire) begin
         mem_valid_d     = 1'b1;
         mem_result_d    = alu_result;
         mem_rs2_data_d  = fwd_rs2;
         mem_rd_d        = rd_q;
         mem_is_load_d   = is_load_q;
         mem_reg_write_d = reg_write_q & ~ex_branch;
      end else if (mem_ready) begin
         mem_valid_d = 1'b0;
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: payload registers are cleared along with the valid bits so
         // the outputs read a defined 0 throughout reset, not stale data.
         ex_valid_q      <= 1'b0;
         pc_q            <= '0;
         imm_q           <= '0;
         rs1_data_q      <= '0;
         rs2_data_q      <= '0;
         rs1_q           <= '0;
         rs2_q           <= '0;
         rd_q            <= '0;
         alu_op_q        <= ALU_ADD;
         use_imm_q       <= 1'b0;
         is_branch_q     <= 1'b0;
         is_load_q       <= 1'b0;
         reg_write_q     <= 1'b0;
         mem_valid_q     <= 1'b0;
         mem_result_q    <= '0;
         mem_rs2_data_q  <= '0;
         mem_rd_q        <= '0;
         mem_is_load_q   <= 1'b0;
         mem_reg_write_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         ex_valid_q      <= ex_valid_d;
         pc_q            <= pc_d;
         imm_q           <= imm_d;
         rs1_data_q      <= rs1_data_d;
         rs2_data_q      <= rs2_data_d;
         rs1_q           <= rs1_d;
         rs2_q           <= rs2_d;
         rd_q            <= rd_d;
         alu_op_q        <= alu_op_d;
         use_imm_q       <= use_imm_d;
         is_branch_q     <= is_branch_d;
         is_load_q       <= is_load_d;
         reg_write_q     <= reg_write_d;
         mem_valid_q     <= mem_valid_d;
         mem_result_q    <= mem_result_d;
         mem_rs2_data_q  <= mem_rs2_data_d;
         mem_rd_q        <= mem_rd_d;
         mem_is_load_q   <= mem_is_load_d;
         mem_reg_write_q <= mem_reg_write_d;
      end
   end

   assign mem_valid     = mem_valid_q;
   assign mem_result    = mem_result_q;
   assign mem_rs2_data  = mem_rs2_data_q;
   assign mem_rd        = mem_rd_q;
   assign mem_is_load   = mem_is_load_q;
   assign mem_reg_write = mem_reg_write_q;

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage -- directed self-checking bench for ex_stage.
// A small combinational ALU model answers the DUT's operand outputs.
// Inputs change 1 time unit after a rising edge; outputs are sampled one
// further time unit later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_ex_stage;
   import core_pkg::*;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          id_valid;
   logic          id_ready;
   logic [W-1:0]  id_pc, id_imm, id_rs1_data, id_rs2_data;
   logic [4:0]    id_rs1, id_rs2, id_rd;
   alu_op_t       id_alu_op;
   logic          id_use_imm, id_is_branch, id_is_load, id_reg_write;
   logic [W-1:0]  alu_op1, alu_op2;
   alu_op_t       alu_operation;
   logic [W-1:0]  alu_result;
   logic          wb_valid;
   logic [4:0]    wb_rd;
   logic [W-1:0]  wb_data;
   logic          mem_valid, mem_ready;
   logic [W-1:0]  mem_result, mem_rs2_data;
   logic [4:0]    mem_rd;
   logic          mem_is_load, mem_reg_write;
   logic          redirect_valid;
   logic [W-1:0]  redirect_pc;

   int checks   = 0;
   int failures = 0;

   ex_stage #(.Data_Width(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_pc(id_pc), .id_imm(id_imm),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_alu_op(id_alu_op),
      .id_use_imm(id_use_imm), .id_is_branch(id_is_branch),
      .id_is_load(id_is_load), .id_reg_write(id_reg_write),
      .alu_op1(alu_op1), .alu_op2(alu_op2),
      .alu_operation(alu_operation), .alu_result(alu_result),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_result(mem_result), .mem_rs2_data(mem_rs2_data),
      .mem_rd(mem_rd), .mem_is_load(mem_is_load),
      .mem_reg_write(mem_reg_write),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   // External ALU model; SUB is op2 - op1, branches return taken in bit 0.
   always_comb begin
      alu_result = '0;
      case (alu_operation)
         ALU_ADD: alu_result = alu_op1 + alu_op2;
         ALU_SUB: alu_result = alu_op2 - alu_op1;
         ALU_SLL: alu_result = alu_op1 << alu_op2[4:0];
         ALU_BEQ: alu_result = {31'b0, alu_op1 == alu_op2};
         ALU_BNE: alu_result = {31'b0, alu_op1 != alu_op2};
         default: alu_result = '0;
      endcase
   end

   task automatic check(input string tag, input logic [W-1:0] got,
                        input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input alu_op_t op, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [W-1:0] d1, input logic [W-1:0] d2,
                        input logic [W-1:0] imm, input logic [W-1:0] pc,
                        input logic use_imm, input logic is_br,
                        input logic is_ld, input logic rw);
      id_valid     = 1'b1;
      id_alu_op    = op;
      id_rs1       = rs1;
      id_rs2       = rs2;
      id_rd        = rd;
      id_rs1_data  = d1;
      id_rs2_data  = d2;
      id_imm       = imm;
      id_pc        = pc;
      id_use_imm   = use_imm;
      id_is_branch = is_br;
      id_is_load   = is_ld;
      id_reg_write = rw;
   endtask

   task automatic idle();
      id_valid = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      mem_ready = 1'b1;
      wb_valid  = 1'b0;
      wb_rd     = '0;
      wb_data   = '0;
      issue(ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle();

      // Reset state
      #1;
      check("rst_mem_valid", W'(mem_valid), 0);
      check("rst_id_ready", W'(id_ready), 1);
      check("rst_redirect", W'(redirect_valid), 0);
      check("rst_alu_op1", alu_op1, 0);
      check("rst_alu_operation", W'(alu_operation), W'(ALU_ADD));
      cyc();
      cyc();
      rst_n = 1'b1;

      // ADD x3,x1,x2 (5+7), accepted on the first edge after reset
      issue(ALU_ADD, 1, 2, 3, 5, 7, 0, 0, 0, 0, 0, 1);
      cyc();
      check("add_op1", alu_op1, 5);
      check("add_op2", alu_op2, 7);
      idle();
      #1 check("add_id_ready", W'(id_ready), 1);
      cyc();
      check("add_mem_valid", W'(mem_valid), 1);
      check("add_mem_result", mem_result, 12);
      check("add_mem_rd", W'(mem_rd), 3);

      // SUB x4,x1,x2 (10-3): operands swapped
      issue(ALU_SUB, 1, 2, 4, 10, 3, 0, 0, 0, 0, 0, 1);
      cyc();
      check("sub_op1", alu_op1, 3);
      check("sub_op2", alu_op2, 10);
      idle();
      cyc();
      check("sub_mem_result", mem_result, 7);

      // SLL x10,x1,3 with immediate: 1 << 3
      issue(ALU_SLL, 1, 0, 10, 1, 0, 3, 0, 1, 0, 0, 1);
      cyc();
      check("sll_op2", alu_op2, 3);
      idle();
      cyc();
      check("sll_mem_result", mem_result, 8);

      // ADD x5=1+2, then ADD x6,x5,x5; EX/MEM beats WB (99)
      issue(ALU_ADD, 1, 2, 5, 1, 2, 0, 0, 0, 0, 0, 1);
      cyc();
      issue(ALU_ADD, 5, 5, 6, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc();
      idle();
      wb_valid = 1'b1;
      wb_rd    = 5;
      wb_data  = 99;
      #1;
      check("fwd_op1", alu_op1, 3);
      check("fwd_op2", alu_op2, 3);
      cyc();
      check("fwd_mem_result", mem_result, 6);
      wb_valid = 1'b0;

      // LW x7 (100+4), then ADD x8,x7,x0 stalled with mem_ready low
      issue(ALU_ADD, 1, 0, 7, 100, 0, 4, 0, 1, 0, 1, 1);
      cyc();
      issue(ALU_ADD, 7, 0, 8, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc();
      idle();
      mem_ready = 1'b0;
      check("lu_mem_is_load", W'(mem_is_load), 1);
      for (int i = 0; i < 3; i++) begin
         #1 check("lu_hold_id_ready", W'(id_ready), 0);
         cyc();
      end
      check("lu_payload_stable", mem_result, 104);
      mem_ready = 1'b1;
      #1 check("lu_hold_drain", W'(id_ready), 0);
      cyc();
      check("lu_mem_drained", W'(mem_valid), 0);
      wb_valid = 1'b1;
      wb_rd    = 7;
      wb_data  = 32'h55;
      #1;
      check("lu_fire", W'(id_ready), 1);
      check("lu_wb_fwd", alu_op1, 32'h55);
      cyc();
      check("lu_mem_result", mem_result, 32'h55);
      check("lu_mem_rd", W'(mem_rd), 8);
      wb_valid = 1'b0;

      // BEQ taken: target 0x100 + 0xFFFFFFF0 wraps to 0xF0
      issue(ALU_BEQ, 1, 2, 0, 4, 4, 32'hFFFF_FFF0, 32'h100, 0, 1, 0, 1);
      cyc();
      issue(ALU_ADD, 1, 2, 9, 1, 1, 0, 0, 0, 0, 0, 1);
      #1;
      check("beq_redirect", W'(redirect_valid), 1);
      check("beq_target", redirect_pc, 32'hF0);
      check("beq_id_ready", W'(id_ready), 1);
      cyc();
      idle();
      check("beq_squash_op1", alu_op1, 0);
      check("beq_redirect_clr", W'(redirect_valid), 0);
      check("beq_mem_valid", W'(mem_valid), 1);
      check("beq_no_write", W'(mem_reg_write), 0);

      // BEQ not taken: no redirect, pc reads 0
      issue(ALU_BEQ, 1, 2, 0, 4, 5, 32'h10, 32'h200, 0, 1, 0, 0);
      cyc();
      idle();
      #1;
      check("bnt_redirect", W'(redirect_valid), 0);
      check("bnt_pc", redirect_pc, 0);
      cyc();

      // Reset mid-stall clears both registers before the next edge
      issue(ALU_ADD, 1, 0, 7, 100, 0, 4, 0, 1, 0, 1, 1);
      cyc();
      issue(ALU_ADD, 7, 0, 8, 0, 0, 0, 0, 0, 0, 0, 1);
      cyc();
      idle();
      mem_ready = 1'b0;
      #1 check("rs_pre_stall", W'(mem_valid), 1);
      #1 rst_n = 1'b0;
      #1;
      check("rs_mem_valid", W'(mem_valid), 0);
      check("rs_id_ready", W'(id_ready), 1);
      check("rs_alu_op1", alu_op1, 0);
      check("rs_redirect", W'(redirect_valid), 0);
      check("rs_mem_result", mem_result, 0);
      cyc();
      rst_n = 1'b1;
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter Data_Width, default 32, datapath width; all data ports below are Data_Width bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 id_valid / id_ready  in / out  1 / 1  decode-to-execute handshake; transfer when both are high.
REQ-005 id_pc, id_imm, id_rs1_data, id_rs2_data  in  Data_Width each  decoded instruction payload.
REQ-006 id_rs1, id_rs2, id_rd  in  5 each  register indices.
REQ-007 id_alu_op  in  ALU_OP (core package)  requested operation.
REQ-008 id_use_imm, id_is_branch, id_is_load, id_reg_write  in  1 each  control flags.
REQ-009 alu_op1, alu_op2  out  Data_Width each  operands driven to the ALU.
REQ-010 alu_operation  out  ALU_OP  operation driven to the ALU.
REQ-011 alu_result  in  Data_Width  combinational ALU result for the current operands.
REQ-012 wb_valid, wb_rd, wb_data  in  1 / 5 / Data_Width  writeback forwarding source.
REQ-013 mem_valid / mem_ready  out / in  1 / 1  execute-to-memory handshake.
REQ-014 mem_result, mem_rs2_data, mem_rd, mem_is_load, mem_reg_write  out  Data_Width / Data_Width / 5 / 1 / 1  EX/MEM register contents.
REQ-015 redirect_valid, redirect_pc  out  1 / Data_Width  taken-branch redirect to fetch.

Function
REQ-016 ID/EX register (ex_valid plus payload) SHALL load on id_valid & id_ready; id_ready = ~ex_valid | ex_fire.
REQ-017 Forwarded rs1/rs2 values SHALL use this priority: the EX/MEM entry (mem_valid, mem_reg_write, mem_rd match, not a load), then WB (wb_valid, wb_rd match), then the ID/EX register value; index 0 is never forwarded and always reads the captured value.
REQ-018 Load-use hold SHALL assert when a source index matches a valid EX/MEM load with nonzero mem_rd; ex_fire is blocked until that entry leaves EX/MEM.
REQ-019 ex_fire = ex_valid & ~hold & (~mem_valid | mem_ready).
REQ-020 Operand mapping: alu_op1 = fwd_rs1 and alu_op2 = (id_use_imm ? imm : fwd_rs2), except SUB, which SHALL drive alu_op1 = fwd_rs2 and alu_op2 = fwd_rs1 (the ALU computes op2 - op1).
REQ-021 Shifts SHALL use the same mapping; the ALU consumes alu_op2[4:0] as the shift amount.
REQ-022 Branch ops (BEQ..BLTU) SHALL drive alu_op1 = fwd_rs1 and alu_op2 = fwd_rs2, and treat alu_result[0] as the taken flag.
REQ-023 Branch target SHALL equal pc + imm, computed locally, wrapping modulo 2^Data_Width with no saturation.
REQ-024 redirect_valid SHALL be combinational and asserted only in an ex_fire cycle of a branch with taken = 1; redirect_pc = target in that cycle, 0 otherwise.
REQ-025 On a redirect cycle the ID/EX register SHALL load a bubble (ex_valid = 0) even if id_valid is high; upstream treats the handshake as accepted and squashed.
REQ-026 On ex_fire, EX/MEM SHALL capture alu_result, fwd_rs2, rd, is_load, and reg_write; branches SHALL set mem_reg_write = 0.
REQ-027 mem_valid: set on ex_fire; cleared on mem_ready without ex_fire; held while ~mem_ready.
REQ-028 EX/MEM payload SHALL remain stable while mem_valid & ~mem_ready.
REQ-029 When no ID/EX entry is valid, alu_operation and alu_op* SHALL be driven to ADD with 0, 0.

Reset
REQ-030 Asserting rst_n low SHALL immediately clear ex_valid, mem_valid, and all payload registers to 0; redirect_valid SHALL read 0 during reset.
REQ-031 An ID/EX entry or EX/MEM entry in flight at reset SHALL be discarded with no redirect.
REQ-032 First transfer SHALL be accepted on the first rising edge after rst_n deasserts with id_valid high.

Verification
REQ-033 ADD x3,x1,x2 with x1=5, x2=7, mem_ready=1 -> alu_op1=5, alu_op2=7; next cycle mem_valid=1, mem_result=12, mem_rd=3.
REQ-034 SUB x4,x1,x2 with x1=10, x2=3 -> alu_op1=3, alu_op2=10, mem_result=7.
REQ-035 Back-to-back dependent instructions: ADD x5=1+2, then ADD x6,x5,x5 -> EX/MEM forward, mem_result=6; with WB also supplying x5=99, EX/MEM still wins.
REQ-036 LW x7 in EX/MEM, then ADD x8,x7,x0 in EX with mem_ready=0 for 3 cycles -> ex_fire=0 and id_ready=0 throughout; fires only after the load reaches WB and forwards from WB.
REQ-037 BEQ x1,x2 with x1=x2=4, pc=0x100, imm=0xFFFFFFF0, id_valid=1 -> redirect_valid=1, redirect_pc=0xF0, next ex_valid=0, mem_reg_write=0.
REQ-038 rst_n pulled low mid-stall with mem_valid=1 -> mem_valid=0 and ex_valid=0 immediately, before the next clock edge.
